// File: rtl/keypad_matrix_scanner.sv
// Column-at-a-time keypad matrix scanner. Rows are synchronised, sampled once per
// column slot, and whole-frame snapshots are debounced before reaching out_keys.
module keypad_matrix_scanner #(
    parameter int N_COLUMN      = 4,
    parameter int N_ROW         = 4,
    parameter int SLOT_LEN      = 4,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_ROW-1:0]          row,
    output logic [N_COLUMN-1:0]       column,
    output logic [N_COLUMN*N_ROW-1:0] out_keys,
    output logic                      data_valid,
    output logic                      multi_key
);

    localparam int KEYS   = N_COLUMN * N_ROW;
    localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int COL_W  = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1;
    localparam int CNT_W  = $clog2(STABLE_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLUMN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Two or more bits set: clearing the lowest set bit still leaves something.
    function automatic logic multi_bits(input logic [KEYS-1:0] v);
        return (v & (v - KEYS'(1))) != '0;
    endfunction

    logic [N_ROW-1:0]  row_s1_q, row_s2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [KEYS-1:0]   frame_raw_q, frame_raw_d;
    logic [KEYS-1:0]   frame_prev_q, frame_prev_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [KEYS-1:0]   out_keys_q, out_keys_d;
    logic              data_valid_q, data_valid_d;
    logic              multi_key_q, multi_key_d;

    logic              sample;
    logic              frame_end;
    logic              load;
    logic [KEYS-1:0]   snap;

    assign sample     = (slot_q == SLOT_LAST);
    assign frame_end  = sample && (col_q == COL_LAST);
    assign column     = N_COLUMN'(1) << col_q;
    assign out_keys   = out_keys_q;
    assign data_valid = data_valid_q;
    assign multi_key  = multi_key_q;

    // Frame so far with the currently driven column's rows merged in.
    always_comb begin
        snap = frame_raw_q;
        for (int r = 0; r < N_ROW; r++) begin
            snap[r*N_COLUMN + int'(col_q)] = row_s2_q[r];
        end
    end

    always_comb begin
        slot_d       = sample ? '0 : slot_q + 1'b1;
        col_d        = col_q;
        frame_raw_d  = frame_raw_q;
        frame_prev_d = frame_prev_q;
        stable_cnt_d = stable_cnt_q;
        data_valid_d = frame_end;
        if (sample) begin
            col_d       = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            frame_raw_d = snap;
        end
        if (frame_end) begin
            frame_prev_d = snap;
            if (snap == frame_prev_q) begin
                stable_cnt_d = (stable_cnt_q >= CNT_MAX) ? CNT_MAX : stable_cnt_q + CNT_ONE;
            end else begin
                stable_cnt_d = CNT_ONE;
            end
        end
        load        = frame_end && (stable_cnt_d >= CNT_MAX);
        out_keys_d  = load ? snap : out_keys_q;
        multi_key_d = load ? multi_bits(snap) : multi_key_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q     <= '0;
            row_s2_q     <= '0;
            slot_q       <= '0;
            col_q        <= '0;
            frame_raw_q  <= '0;
            frame_prev_q <= '0;
            stable_cnt_q <= '0;
            out_keys_q   <= '0;
            data_valid_q <= 1'b0;
            multi_key_q  <= 1'b0;
        end else begin
            row_s1_q     <= row;
            row_s2_q     <= row_s1_q;
            slot_q       <= slot_d;
            col_q        <= col_d;
            frame_raw_q  <= frame_raw_d;
            frame_prev_q <= frame_prev_d;
            stable_cnt_q <= stable_cnt_d;
            out_keys_q   <= out_keys_d;
            data_valid_q <= data_valid_d;
            multi_key_q  <= multi_key_d;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model drives rows from the column pins,
// and a frame-history model predicts the debounced key map cycle by cycle.
module tb_keypad_matrix_scanner;

    localparam int NC    = 4;
    localparam int NR    = 4;
    localparam int SLOT  = 4;
    localparam int STAB  = 3;
    localparam int FRAME = NC * SLOT;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     row;
    logic [NC-1:0]     column;
    logic [NC*NR-1:0]  out_keys;
    logic              data_valid;
    logic              multi_key;

    logic [NC*NR-1:0]  keys;
    logic [NC*NR-1:0]  hist[$];
    logic [NC*NR-1:0]  exp_keys;
    logic              exp_multi;
    int                edge_n;
    int                n_checks;
    int                n_errors;

    keypad_matrix_scanner #(
        .N_COLUMN(NC), .N_ROW(NR), .SLOT_LEN(SLOT), .STABLE_FRAMES(STAB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .column(column),
        .out_keys(out_keys), .data_valid(data_valid), .multi_key(multi_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad: a pressed key connects its column drive to its row.
    always_comb begin
        row = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (keys[r*NC + c] && column[c]) row[r] = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output is loaded when the last STAB frame snapshots since reset are identical.
    task automatic model_frame(input logic [NC*NR-1:0] k);
        bit same;
        int n;
        hist.push_back(k);
        n = hist.size();
        if (n >= STAB) begin
            same = 1'b1;
            for (int j = 1; j < STAB; j++)
                if (hist[n-1-j] != k) same = 1'b0;
            if (same) begin
                exp_keys  = k;
                exp_multi = ($countones(k) >= 2);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n % FRAME == 0) model_frame(keys);
        check_val("column", 32'(column), 32'(1) << ((edge_n / SLOT) % NC));
        check_val("data_valid", 32'(data_valid), 32'(edge_n % FRAME == 0));
        check_val("out_keys", 32'(out_keys), 32'(exp_keys));
        check_val("multi_key", 32'(multi_key), 32'(exp_multi));
    endtask

    task automatic run_frames(input logic [NC*NR-1:0] k, input int n);
        keys = k;
        repeat (n * FRAME) step();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_column"}, 32'(column), 32'h1);
        check_val({tag, "_out_keys"}, 32'(out_keys), 32'h0);
        check_val({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        check_val({tag, "_multi_key"}, 32'(multi_key), 32'h0);
    endtask

    task automatic hold_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_async");
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_reset_state("rst_hold");
        end
        rst_n     = 1'b1;
        edge_n    = 0;
        hist.delete();
        exp_keys  = '0;
        exp_multi = 1'b0;
    endtask

    initial begin
        logic [NC*NR-1:0] pat;
        n_checks  = 0;
        n_errors  = 0;
        edge_n    = 0;
        keys      = '0;
        exp_keys  = '0;
        exp_multi = 1'b0;
        rst_n     = 1'b1;
        #3;
        hold_reset(3);

        // Idle scanning
        run_frames('0, 4);
        check_val("idle_out", 32'(out_keys), 32'h0);

        // Single press row1/col2, appears on third frame
        run_frames(16'h0040, 2);
        check_val("press_not_yet", 32'(out_keys), 32'h0);
        run_frames(16'h0040, 1);
        check_val("single_press", 32'(out_keys), 32'h0040);
        check_val("single_multi", 32'(multi_key), 32'h0);

        // Release
        run_frames('0, 2);
        check_val("release_not_yet", 32'(out_keys), 32'h0040);
        run_frames('0, 1);
        check_val("release", 32'(out_keys), 32'h0);

        // Bounce then hold
        for (int f = 0; f < 5; f++) run_frames((f % 2) ? 16'h0040 : 16'h0000, 1);
        check_val("bounce_held_off", 32'(out_keys), 32'h0);
        run_frames(16'h0040, 2);
        check_val("bounce_two_stable", 32'(out_keys), 32'h0);
        run_frames(16'h0040, 1);
        check_val("bounce_settled", 32'(out_keys), 32'h0040);

        // Multi-key
        run_frames('0, 3);
        run_frames(16'h8001, 3);
        check_val("multi_keys", 32'(out_keys), 32'h8001);
        check_val("multi_flag", 32'(multi_key), 32'h1);

        // Randomised frames, biased toward holding a pattern long enough to load
        pat = '0;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: pat = '0;
                    1: pat = 16'(1) << $urandom_range(0, NC*NR-1);
                    2: pat = (16'(1) << $urandom_range(0, NC*NR-1)) |
                             (16'(1) << $urandom_range(0, NC*NR-1));
                    default: pat = 16'($urandom);
                endcase
            end
            run_frames(pat, 1);
        end

        // Reset in the middle of column 2 with keys held
        run_frames(16'h8041, 3);
        check_val("pre_reset_keys", 32'(out_keys), 32'h8041);
        repeat (9) step();
        check_val("pre_reset_column", 32'(column), 32'h4);
        hold_reset(2);
        run_frames(16'h8041, 2);
        check_val("reaccept_not_yet", 32'(out_keys), 32'h0);
        run_frames(16'h8041, 1);
        check_val("reaccept_keys", 32'(out_keys), 32'h8041);
        check_val("reaccept_multi", 32'(multi_key), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
